// File: rtl/hazard_pkg.sv
// Shared types for the pipeline hazard controller: FSM encoding, control bundle,
// watchdog counter width and the load-use dependence test.
package hazard_pkg;

   typedef enum logic [1:0] {
      BOOT     = 2'd0,
      RUN      = 2'd1,
      MEM_WAIT = 2'd2
   } state_t;

   localparam int WAIT_W = 16;

   typedef struct packed {
      logic pc_write;
      logic if_id_write;
      logic if_id_flush;
      logic id_ex_flush;
      logic ex_mem_write;
      logic mem_wb_write;
   } ctrl_t;

   // A load in EX whose destination is read by the instruction in ID; x0 never conflicts.
   function automatic logic load_use_hit(
      input logic [4:0] rs1,
      input logic [4:0] rs2,
      input logic       uses_rs1,
      input logic       uses_rs2,
      input logic [4:0] rd,
      input logic       memread,
      input logic       regwrite
   );
      return memread & regwrite & (rd != 5'd0) &
             ((uses_rs1 & (rd == rs1)) | (uses_rs2 & (rd == rs2)));
   endfunction

endpackage

// File: rtl/hazard_unit_if.sv
// Pipeline-to-hazard-unit bundle: register/hazard info in, stage enables and flushes out.
interface hazard_unit_if;

   logic [4:0] if_id_rs1;
   logic [4:0] if_id_rs2;
   logic       if_id_uses_rs1;
   logic       if_id_uses_rs2;
   logic [4:0] id_ex_rd;
   logic       id_ex_memread;
   logic       id_ex_regwrite;
   logic       ex_branch_taken;
   logic       dmem_req;
   logic       dmem_ready;

   logic       pc_write;
   logic       if_id_write;
   logic       if_id_flush;
   logic       id_ex_flush;
   logic       ex_mem_write;
   logic       mem_wb_write;

   modport master (
      output if_id_rs1, if_id_rs2, if_id_uses_rs1, if_id_uses_rs2,
             id_ex_rd, id_ex_memread, id_ex_regwrite, ex_branch_taken,
             dmem_req, dmem_ready,
      input  pc_write, if_id_write, if_id_flush, id_ex_flush,
             ex_mem_write, mem_wb_write
   );

   modport slave (
      input  if_id_rs1, if_id_rs2, if_id_uses_rs1, if_id_uses_rs2,
             id_ex_rd, id_ex_memread, id_ex_regwrite, ex_branch_taken,
             dmem_req, dmem_ready,
      output pc_write, if_id_write, if_id_flush, id_ex_flush,
             ex_mem_write, mem_wb_write
   );

endinterface

// File: rtl/hazard_unit_sat_counter.sv
// Saturating up-counter with synchronous clear (clear wins over inc).
module sat_counter #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             inc,
   input  logic             clear,
   output logic [WIDTH-1:0] count
);

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (inc && (count != '1)) begin
         count <= count + 1'b1;
      end
   end

endmodule

// File: rtl/hazard_unit.sv
// Stall/flush controller for the 5-stage core: boot flush, memory freeze, branch flush,
// load-use bubble and memory watchdog. Define HAZARD_PERF_EN to build the perf counters.
module hazard_unit
   import hazard_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 255,
   parameter int CNT_W          = 32
) (
   input  logic             clk,
   input  logic             rst,
   hazard_unit_if.slave     hz,
   output logic             mem_timeout,
   output logic [CNT_W-1:0] stall_count,
   output logic [CNT_W-1:0] flush_count,
   output logic [CNT_W-1:0] memwait_count
);

   localparam logic [WAIT_W-1:0] TIMEOUT_LAST = WAIT_W'(TIMEOUT_CYCLES - 1);

   state_t            state;
   state_t            state_next;
   ctrl_t             ctrl;
   logic              active;
   logic              freeze;
   logic              branch_flush;
   logic              load_use;
   logic              wait_inc;
   logic [WAIT_W-1:0] wait_cnt;

   assign active       = (state != BOOT);
   assign freeze       = active & hz.dmem_req & ~hz.dmem_ready;
   assign branch_flush = active & ~freeze & hz.ex_branch_taken;
   // A taken branch squashes the dependent instruction, so it masks the load-use stall.
   assign load_use     = active & ~freeze & ~hz.ex_branch_taken &
                         load_use_hit(hz.if_id_rs1, hz.if_id_rs2, hz.if_id_uses_rs1,
                                      hz.if_id_uses_rs2, hz.id_ex_rd, hz.id_ex_memread,
                                      hz.id_ex_regwrite);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= BOOT;
      end else begin
         state <= state_next;
      end
   end

   // NOTE: every always_comb output gets a default first, so no path can infer a latch.
   always_comb begin
      state_next = state;
      ctrl       = '{pc_write: 1'b1, if_id_write: 1'b1, if_id_flush: 1'b0,
                     id_ex_flush: 1'b0, ex_mem_write: 1'b1, mem_wb_write: 1'b1};
      case (state)
         BOOT: begin
            state_next = RUN;
            ctrl       = '{pc_write: 1'b0, if_id_write: 1'b0, if_id_flush: 1'b1,
                           id_ex_flush: 1'b1, ex_mem_write: 1'b0, mem_wb_write: 1'b0};
         end
         RUN, MEM_WAIT: begin
            state_next = freeze ? MEM_WAIT : RUN;
            if (freeze) begin
               ctrl = '0;
            end else if (branch_flush) begin
               ctrl.if_id_flush = 1'b1;
               ctrl.id_ex_flush = 1'b1;
            end else if (load_use) begin
               ctrl.pc_write    = 1'b0;
               ctrl.if_id_write = 1'b0;
               ctrl.id_ex_flush = 1'b1;
            end
         end
         default: begin
            state_next = BOOT;
         end
      endcase
   end

   assign hz.pc_write     = ctrl.pc_write;
   assign hz.if_id_write  = ctrl.if_id_write;
   assign hz.if_id_flush  = ctrl.if_id_flush;
   assign hz.id_ex_flush  = ctrl.id_ex_flush;
   assign hz.ex_mem_write = ctrl.ex_mem_write;
   assign hz.mem_wb_write = ctrl.mem_wb_write;

   // Watchdog counts cycles spent waiting in MEM_WAIT; any unfrozen cycle clears it.
   assign wait_inc = (state == MEM_WAIT) & freeze;

   sat_counter #(.WIDTH(WAIT_W)) u_wait_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc   (wait_inc),
      .clear (~wait_inc),
      .count (wait_cnt)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mem_timeout <= 1'b0;
      end else if (wait_inc && (wait_cnt == TIMEOUT_LAST)) begin
         mem_timeout <= 1'b1;
      end
   end

`ifdef HAZARD_PERF_EN
   sat_counter #(.WIDTH(CNT_W)) u_stall_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc   (load_use),
      .clear (1'b0),
      .count (stall_count)
   );

   sat_counter #(.WIDTH(CNT_W)) u_flush_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc   (branch_flush),
      .clear (1'b0),
      .count (flush_count)
   );

   sat_counter #(.WIDTH(CNT_W)) u_memwait_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc   (freeze),
      .clear (1'b0),
      .count (memwait_count)
   );
`else
   assign stall_count   = '0;
   assign flush_count   = '0;
   assign memwait_count = '0;
`endif

endmodule

// File: tb/tb_hazard_unit.sv
// Scoreboard bench for hazard_unit: directed scenarios plus random traffic against a
// cycle-level behavioural model; a negedge monitor pops and compares expectations.
module tb_hazard_unit;

   localparam int TIMEOUT = 8;
   localparam int CNT_W   = 32;

   typedef struct {
      logic [5:0]       ctrl;
      logic             tmo;
      logic [CNT_W-1:0] stall;
      logic [CNT_W-1:0] flush;
      logic [CNT_W-1:0] mw;
      int               cyc;
   } exp_t;

   logic             clk;
   logic             rst;
   logic             mem_timeout;
   logic [CNT_W-1:0] stall_count;
   logic [CNT_W-1:0] flush_count;
   logic [CNT_W-1:0] memwait_count;

   hazard_unit_if hz ();

   hazard_unit #(
      .TIMEOUT_CYCLES (TIMEOUT),
      .CNT_W          (CNT_W)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .hz            (hz),
      .mem_timeout   (mem_timeout),
      .stall_count   (stall_count),
      .flush_count   (flush_count),
      .memwait_count (memwait_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   exp_t sb[$];
   int   errors = 0;
   int   checks = 0;
   int   cyc_n  = 0;
   bit   done   = 0;

   // Behavioural model: boot pending, length of the current freeze run, sticky flag, counters.
   bit      m_boot = 1;
   int      m_run  = 0;
   bit      m_tmo  = 0;
   longint  m_stall = 0;
   longint  m_flush = 0;
   longint  m_mw    = 0;

   task automatic check(input string name, input int cyc, input logic [63:0] act,
                        input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
      end
   endtask

   task automatic drive(input bit r, input logic [4:0] rs1, input logic [4:0] rs2,
                        input bit u1, input bit u2, input logic [4:0] rd,
                        input bit mr, input bit rw, input bit br, input bit req,
                        input bit rdy);
      exp_t e;
      bit   frz;
      bit   lu;
      rst                = r;
      hz.if_id_rs1       = rs1;
      hz.if_id_rs2       = rs2;
      hz.if_id_uses_rs1  = u1;
      hz.if_id_uses_rs2  = u2;
      hz.id_ex_rd        = rd;
      hz.id_ex_memread   = mr;
      hz.id_ex_regwrite  = rw;
      hz.ex_branch_taken = br;
      hz.dmem_req        = req;
      hz.dmem_ready      = rdy;
      if (r) begin
         m_boot  = 1;
         m_run   = 0;
         m_tmo   = 0;
         m_stall = 0;
         m_flush = 0;
         m_mw    = 0;
      end
      frz = req && !rdy;
      lu  = mr && rw && (rd != 0) && ((u1 && rd == rs1) || (u2 && rd == rs2));
      // ctrl order: pc_write, if_id_write, if_id_flush, id_ex_flush, ex_mem_write, mem_wb_write
      if (m_boot)      e.ctrl = 6'b001100;
      else if (frz)    e.ctrl = 6'b000000;
      else if (br)     e.ctrl = 6'b111111;
      else if (lu)     e.ctrl = 6'b000111;
      else             e.ctrl = 6'b110011;
      e.tmo = m_tmo;
`ifdef HAZARD_PERF_EN
      e.stall = CNT_W'(m_stall);
      e.flush = CNT_W'(m_flush);
      e.mw    = CNT_W'(m_mw);
`else
      e.stall = '0;
      e.flush = '0;
      e.mw    = '0;
`endif
      e.cyc = cyc_n;
      cyc_n++;
      sb.push_back(e);
      @(posedge clk);
      if (!r) begin
         if (m_boot) begin
            m_boot = 0;
         end else begin
            if (frz) begin
               m_run++;
               m_mw++;
               // The first frozen cycle is spent in RUN; the rest are wait cycles.
               if (m_run - 1 == TIMEOUT) m_tmo = 1;
            end else begin
               m_run = 0;
            end
            if (!frz && br) m_flush++;
            if (!frz && !br && lu) m_stall++;
         end
      end
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic rand_cycle(input bit slow_mem);
      bit req;
      bit rdy;
      req = ($urandom % 2) == 1;
      rdy = slow_mem ? (($urandom % 5) == 0) : (($urandom % 3) != 0);
      drive(0, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
            bit'($urandom % 2), bit'($urandom % 2), 5'($urandom_range(0, 3)),
            bit'($urandom % 2), bit'($urandom % 2), ($urandom % 4) == 0, req, rdy);
   endtask

   // Monitor: one expectation per cycle, sampled on the falling edge.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (sb.size() > 0) begin
            e = sb.pop_front();
            check("ctrl", e.cyc, {58'd0, hz.pc_write, hz.if_id_write, hz.if_id_flush,
                                  hz.id_ex_flush, hz.ex_mem_write, hz.mem_wb_write},
                  {58'd0, e.ctrl});
            check("mem_timeout", e.cyc, {63'd0, mem_timeout}, {63'd0, e.tmo});
            check("stall_count", e.cyc, 64'(stall_count), 64'(e.stall));
            check("flush_count", e.cyc, 64'(flush_count), 64'(e.flush));
            check("memwait_count", e.cyc, 64'(memwait_count), 64'(e.mw));
         end
      end
   end

   // Stimulus
   initial begin
      rst                = 1'b1;
      hz.if_id_rs1       = '0;
      hz.if_id_rs2       = '0;
      hz.if_id_uses_rs1  = 1'b0;
      hz.if_id_uses_rs2  = 1'b0;
      hz.id_ex_rd        = '0;
      hz.id_ex_memread   = 1'b0;
      hz.id_ex_regwrite  = 1'b0;
      hz.ex_branch_taken = 1'b0;
      hz.dmem_req        = 1'b0;
      hz.dmem_ready      = 1'b0;
      @(posedge clk);
      #1;
      // Reset held 3 cycles, boot cycle, then normal
      for (int i = 0; i < 3; i++) drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      idle(3);
      // Load-use on rs2, then rs1, then rd=0 (no stall), then non-load
      drive(0, 0, 5, 0, 1, 5, 1, 1, 0, 0, 0);
      idle(1);
      drive(0, 7, 0, 1, 0, 7, 1, 1, 0, 0, 0);
      drive(0, 0, 0, 1, 1, 0, 1, 1, 0, 0, 0);
      drive(0, 5, 5, 1, 1, 5, 0, 1, 0, 0, 0);
      drive(0, 5, 5, 0, 0, 5, 1, 1, 0, 0, 0);
      // Branch together with load-use: flush wins, no stall
      drive(0, 0, 5, 0, 1, 5, 1, 1, 1, 0, 0);
      idle(1);
      // Memory wait of 4 cycles then ready
      for (int i = 0; i < 4; i++) drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
      // Branch held across a freeze takes effect when released
      for (int i = 0; i < 2; i++) drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0);
      drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1);
      idle(1);
      // Watchdog: 10 frozen cycles, then ready; flag stays set
      for (int i = 0; i < 10; i++) drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
      idle(3);
      for (int i = 0; i < 150; i++) rand_cycle(0);
      for (int i = 0; i < 80; i++) rand_cycle(1);
      // Reset in the middle of a freeze, then release with the freeze still requested
      for (int i = 0; i < 12; i++) drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
      drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
      drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
      for (int i = 0; i < 3; i++) drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
      // Reset during a load-use stall
      drive(0, 0, 5, 0, 1, 5, 1, 1, 0, 0, 0);
      drive(1, 0, 5, 0, 1, 5, 1, 1, 0, 0, 0);
      drive(0, 0, 5, 0, 1, 5, 1, 1, 0, 0, 0);
      drive(0, 0, 5, 0, 1, 5, 1, 1, 0, 0, 0);
      for (int i = 0; i < 150; i++) rand_cycle(($urandom % 4) == 0);
      done = 1;
   end

   initial begin
      wait (done);
      repeat (4) @(negedge clk);
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL drain: %0d expectations left, expected 0", sb.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL time_limit: bench still running at %0t, expected completion", $time);
      $fatal(1, "time limit");
   end

endmodule

// File: doc/hazard_unit.md
# hazard_unit

Pipeline hazard controller for the 5-stage RISC-V core. It is the stall/flush counterpart of the operand-forwarding logic: it covers the hazards that forwarding cannot resolve. It inserts a one-cycle bubble on load-use dependences, flushes IF/ID and ID/EX on taken branches and jumps, and freezes the whole pipeline while data memory is not ready. A small FSM handles the post-reset flush and memory-wait tracking, including a timeout watchdog.

## Interface
- `TIMEOUT_CYCLES`, 255: consecutive memory-wait cycles before `mem_timeout` sets (1..2^16-1).
- `CNT_W`, 32: width of the performance counters.
- `clk` in 1: core clock; all state updates on the rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `if_id_rs1`, `if_id_rs2` in 5 each: source registers of the instruction in ID.
- `if_id_uses_rs1`, `if_id_uses_rs2` in 1 each: the ID instruction actually reads rs1 / rs2.
- `id_ex_rd` in 5: destination of the instruction in EX.
- `id_ex_memread` in 1: the EX instruction is a load.
- `id_ex_regwrite` in 1: the EX instruction writes `rd`.
- `ex_branch_taken` in 1: branch or jump in EX resolved taken.
- `dmem_req` in 1: the MEM stage is issuing a load or store.
- `dmem_ready` in 1: data memory completes the access this cycle.
- `pc_write` out 1: enable for the PC register.
- `if_id_write` out 1: enable for the IF/ID register.
- `if_id_flush` out 1: load NOP into IF/ID.
- `id_ex_flush` out 1: load bubble (all control bits 0) into ID/EX.
- `ex_mem_write` out 1: enable for the EX/MEM register.
- `mem_wb_write` out 1: enable for the MEM/WB register.
- `mem_timeout` out 1: sticky watchdog flag.
- `stall_count`, `flush_count`, `memwait_count` out `CNT_W` each: performance counters.

## Operation
- FSM states are BOOT, RUN and MEM_WAIT; `rst` forces BOOT.
- **BOOT**
  - Outputs: `pc_write`=0, `if_id_write`=0, `if_id_flush`=1, `id_ex_flush`=1, `ex_mem_write`=0, `mem_wb_write`=0.
  - Transitions unconditionally to RUN on the first clock edge after `rst` falls.
- **Freeze** = `dmem_req & ~dmem_ready`, valid in RUN or MEM_WAIT.
  - Drives all four write enables to 0 and both flushes to 0.
  - From RUN, freeze moves the FSM to MEM_WAIT. From MEM_WAIT, `dmem_ready`=1 (or `dmem_req`=0) returns to RUN.
- **Branch flush** applies when freeze=0 and `ex_branch_taken`=1.
  - `if_id_flush`=1, `id_ex_flush`=1, all write enables 1.
  - The PC target mux lives outside this block. The branch penalty is 2 cycles.
- **Load-use** = `id_ex_memread & id_ex_regwrite & (id_ex_rd!=0) & ((if_id_uses_rs1 & id_ex_rd==if_id_rs1) | (if_id_uses_rs2 & id_ex_rd==if_id_rs2))`.
  - Applies when freeze=0 and branch flush=0.
  - Outputs: `pc_write`=0, `if_id_write`=0, `id_ex_flush`=1, `ex_mem_write`=1, `mem_wb_write`=1.
- **Priority**: BOOT > freeze > branch flush > load-use > normal. Normal means all enables 1 and both flushes 0.
  - Branch and load-use together: the dependent instruction is squashed, so no stall is taken.
  - A taken branch held during a freeze takes effect on the first unfrozen cycle.
- **Watchdog**
  - Wait counter (16 bits) increments each MEM_WAIT cycle and clears on exit to RUN.
  - When it reaches `TIMEOUT_CYCLES`, `mem_timeout` sets and stays set until `rst`.
  - The freeze continues after timeout; the counter saturates.
- Decode is combinational from the state register and the inputs; only the FSM, wait counter, `mem_timeout` and perf counters are registered.

## Timing
- Reset values: state=BOOT, `mem_timeout`=0, all counters 0, outputs as listed for BOOT.
- Load-use costs exactly one bubble: the next cycle the load is in EX/MEM and the normal forwarding path supplies the operand.
- Freeze release is combinational: the cycle `dmem_ready`=1 has all enables = 1.
- Asserting `rst` mid-freeze or mid-stall returns to BOOT immediately and clears `mem_timeout` and all counters.

## Configuration
- `HAZARD_PERF_EN` defined:
  - `stall_count` +1 per load-use cycle.
  - `flush_count` +1 per branch-flush cycle.
  - `memwait_count` +1 per freeze cycle.
  - All three saturate at 2^`CNT_W`-1.
- `HAZARD_PERF_EN` undefined: the three ports exist but are tied to 0, and no counter flops are built.

## Structure
- `hazard_pkg` holds the state encoding (BOOT=2'd0, RUN=2'd1, MEM_WAIT=2'd2) and the wait-counter width constant.
- Sub-module `sat_counter` (parameter width; inputs inc and clear; saturating) is instantiated for the watchdog, and three more times under `HAZARD_PERF_EN`.

## Test plan
1. **Reset and boot.** Hold `rst` 3 cycles then release. During reset and the first edge after: both flushes=1, all enables=0. Next cycle: normal, all enables=1.
2. **Load-use.** `id_ex_rd`=5, `id_ex_memread`=1, `id_ex_regwrite`=1, `if_id_rs2`=5, `if_id_uses_rs2`=1. Exactly 1 cycle with `pc_write`=0, `if_id_write`=0, `id_ex_flush`=1. Also check `id_ex_rd`=0 produces no stall.
3. **Branch vs load-use.** Load-use conditions together with `ex_branch_taken`=1. Both flushes=1, `pc_write`=1, no stall, `flush_count` +1.
4. **Memory wait.** `dmem_req`=1, `dmem_ready`=0 for 4 cycles, then `dmem_ready`=1. All enables=0 for 4 cycles, state MEM_WAIT, `memwait_count`=4. Enables=1 in the ready cycle.
5. **Watchdog.** `TIMEOUT_CYCLES`=8 with `dmem_ready` held 0 for 10 cycles. `mem_timeout` rises after the 8th wait cycle, stays 1 after ready, and clears only on `rst`.
6. **Reset mid-freeze.** Assert `rst` during MEM_WAIT. State returns to BOOT within the same cycle, and `mem_timeout` and all counters read 0.
